// File: rtl/img_action_scheduler.sv
// ============================================================================
// Module   : img_action_scheduler
// Purpose  : Collects and validates a per-pass action list. Issues each action
//            to the image datapath while tracking the working image size.
//            Serialises the 20-bit correlation results MSB first onto a
//            1-bit output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module img_action_scheduler #(
    parameter int DEPTH = 8,
    parameter int RES_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             size_load,
    input  logic [1:0]       image_size,
    input  logic             in_valid2,
    input  logic [2:0]       action,
    output logic             cmd_valid,
    output logic [2:0]       cmd_op,
    output logic [1:0]       cmd_size,
    input  logic             cmd_ready,
    input  logic             dp_done,
    input  logic             res_valid,
    input  logic [RES_W-1:0] res_data,
    output logic             res_ready,
    output logic             out_valid,
    output logic             out_value,
    output logic             busy,
    output logic             seq_err,
    output logic             pass_done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BIT_W = (RES_W > 1) ? $clog2(RES_W) : 1;

    // The list check is done in the closing cycle of COLLECT (the first beat-free
    // cycle), so a failing list reports two cycles after its last beat.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_SERIAL  = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t           state_q;
    logic [2:0]       queue_q [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [IDX_W-1:0] rdptr_q;
    logic [2:0]       last_q;
    logic             ovf_q;
    logic [1:0]       base_size_q;
    logic [1:0]       cur_size_q;
    logic [2:0]       op_q;
    logic [8:0]       remaining_q;
    logic [RES_W-1:0] shift_q;
    logic [BIT_W-1:0] bitcnt_q;
    logic             active_q;
    logic             seq_err_q;

    logic [2:0]       w_head;
    logic             w_skip;
    logic             w_last_bit;
    logic             w_load;
    logic             w_list_ok;

    // Words per correlation pass: (4 << size) squared.
    function automatic logic [8:0] words_for(input logic [1:0] size);
        case (size)
            2'd0:    words_for = 9'd16;
            2'd1:    words_for = 9'd64;
            default: words_for = 9'd256;
        endcase
    endfunction

    assign w_head     = queue_q[rdptr_q];
    assign w_skip     = (state_q == ST_ISSUE) && (w_head == 3'd3) && (cur_size_q == 2'd0);
    assign w_last_bit = active_q && (bitcnt_q == BIT_W'(RES_W - 1));
    assign w_load     = res_valid && res_ready;

    assign cmd_valid  = (state_q == ST_ISSUE) && !w_skip;
    assign cmd_op     = cmd_valid ? w_head : 3'd0;
    assign cmd_size   = cmd_valid ? cur_size_q : 2'd0;
    assign res_ready  = (state_q == ST_SERIAL) && (!active_q || w_last_bit) && (remaining_q != 9'd0);
    assign out_valid  = active_q;
    assign out_value  = active_q & shift_q[RES_W-1];
    assign busy       = (state_q != ST_IDLE);
    assign seq_err    = seq_err_q;
    assign pass_done  = (state_q == ST_DONE);

    // List legality: grayscale first, correlation last, neither in between, no overflow.
    always_comb begin
        w_list_ok = (queue_q[0] <= 3'd2) && (last_q == 3'd7) && !ovf_q;
        for (int i = 1; i < DEPTH; i++) begin
            if (((i + 1) < int'(count_q)) && ((queue_q[i] <= 3'd2) || (queue_q[i] == 3'd7))) begin
                w_list_ok = 1'b0;
            end
        end
    end

    // Sequencing FSM: list capture, command issue, size tracking and pass control.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                queue_q[i] <= 3'd0;
            end
            count_q     <= '0;
            rdptr_q     <= '0;
            last_q      <= 3'd0;
            ovf_q       <= 1'b0;
            base_size_q <= 2'd0;
            cur_size_q  <= 2'd0;
            op_q        <= 3'd0;
            remaining_q <= 9'd0;
            seq_err_q   <= 1'b0;
        end else begin
            seq_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (size_load) begin
                        base_size_q <= (image_size == 2'd3) ? 2'd2 : image_size;
                    end
                    if (in_valid2) begin
                        queue_q[0] <= action;
                        last_q     <= action;
                        count_q    <= CNT_W'(1);
                        rdptr_q    <= '0;
                        ovf_q      <= 1'b0;
                        state_q    <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (in_valid2) begin
                        if (count_q < CNT_W'(DEPTH)) begin
                            queue_q[count_q[IDX_W-1:0]] <= action;
                            last_q  <= action;
                            count_q <= count_q + CNT_W'(1);
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end else if (w_list_ok) begin
                        cur_size_q <= base_size_q;
                        state_q    <= ST_ISSUE;
                    end else begin
                        seq_err_q <= 1'b1;
                        count_q   <= '0;
                        ovf_q     <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (w_skip) begin
                        rdptr_q <= rdptr_q + IDX_W'(1);
                    end else if (cmd_ready) begin
                        op_q    <= w_head;
                        rdptr_q <= rdptr_q + IDX_W'(1);
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dp_done) begin
                        if (op_q == 3'd3) begin
                            cur_size_q <= cur_size_q - 2'd1;
                        end
                        if (op_q == 3'd7) begin
                            remaining_q <= words_for(cur_size_q);
                            state_q     <= ST_SERIAL;
                        end else begin
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_SERIAL: begin
                    if (w_load) begin
                        remaining_q <= remaining_q - 9'd1;
                    end
                    if (w_last_bit && (remaining_q == 9'd0)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    count_q <= '0;
                    rdptr_q <= '0;
                    ovf_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Result shifter: a word loaded on the last bit of the previous one continues seamlessly.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q  <= '0;
            bitcnt_q <= '0;
            active_q <= 1'b0;
        end else if (w_load) begin
            shift_q  <= res_data;
            bitcnt_q <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (w_last_bit) begin
                active_q <= 1'b0;
            end else begin
                shift_q  <= {shift_q[RES_W-2:0], 1'b0};
                bitcnt_q <= bitcnt_q + BIT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_img_action_scheduler.sv
// ============================================================================
// Module   : tb_img_action_scheduler
// Purpose  : Directed self-checking bench for img_action_scheduler. Expected
//            commands and result bits are queued as stimulus is applied and
//            consumed as the design produces them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_img_action_scheduler;

    localparam int RES_W  = 20;
    localparam int DP_LAT = 2;

    logic             clk;
    logic             rst;
    logic             size_load;
    logic [1:0]       image_size;
    logic             in_valid2;
    logic [2:0]       action;
    logic             cmd_valid;
    logic [2:0]       cmd_op;
    logic [1:0]       cmd_size;
    logic             cmd_ready;
    logic             dp_done;
    logic             res_valid;
    logic [RES_W-1:0] res_data;
    logic             res_ready;
    logic             out_valid;
    logic             out_value;
    logic             busy;
    logic             seq_err;
    logic             pass_done;

    img_action_scheduler #(.DEPTH(8), .RES_W(RES_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .size_load  (size_load),
        .image_size (image_size),
        .in_valid2  (in_valid2),
        .action     (action),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_size   (cmd_size),
        .cmd_ready  (cmd_ready),
        .dp_done    (dp_done),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .out_valid  (out_valid),
        .out_value  (out_value),
        .busy       (busy),
        .seq_err    (seq_err),
        .pass_done  (pass_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [1:0] sz;
    } cmd_t;

    cmd_t             exp_cmd[$];
    logic             exp_bits[$];
    logic [RES_W-1:0] src_words[$];
    int               rise_q[$];
    int               dp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int dp_timer = 0;
    int n_outv, n_pass, n_seqerr, n_cmdv, words_acc;
    int ov_first, ov_last, rr_first;
    bit cmdv_prev = 1'b0;
    bit src_en = 1'b0;
    bit src_gap = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: settle handshakes for the coming edge, then observe and drive at the falling edge.
    task automatic cycle();
        cmd_t c;
        if (cmd_valid === 1'b1 && cmd_ready) begin
            if (exp_cmd.size() == 0) begin
                check("cmd_unexpected", 32'(exp_cmd.size()), 32'd1);
            end else begin
                c = exp_cmd.pop_front();
                check("cmd_op", 32'(cmd_op), 32'(c.op));
                check("cmd_size", 32'(cmd_size), 32'(c.sz));
            end
            dp_timer = DP_LAT;
        end
        if (res_valid && res_ready === 1'b1) begin
            for (int b = RES_W - 1; b >= 0; b--) exp_bits.push_back(res_data[b]);
            src_words.delete(0);
            words_acc++;
        end
        @(negedge clk);
        cyc++;
        if (out_valid === 1'b1) begin
            n_outv++;
            if (ov_first < 0) ov_first = cyc;
            ov_last = cyc;
            if (exp_bits.size() == 0) check("out_unexpected", 32'(exp_bits.size()), 32'd1);
            else check("out_bit", 32'(out_value), 32'(exp_bits.pop_front()));
        end else begin
            check("out_idle", 32'(out_value), 32'd0);
        end
        if (pass_done === 1'b1) n_pass++;
        if (seq_err === 1'b1) n_seqerr++;
        if (cmd_valid === 1'b1) n_cmdv++;
        if (cmd_valid === 1'b1 && !cmdv_prev) rise_q.push_back(cyc);
        cmdv_prev = (cmd_valid === 1'b1);
        if (res_ready === 1'b1 && rr_first < 0) rr_first = cyc;
        dp_done = (dp_timer == 1);
        if (dp_done) dp_q.push_back(cyc);
        if (dp_timer > 0) dp_timer--;
        res_valid = src_en && (src_words.size() > 0) && !(src_gap && (cyc % 3 == 0));
        res_data  = (src_words.size() > 0) ? src_words[0] : '0;
    endtask

    task automatic clr();
        n_outv = 0; n_pass = 0; n_seqerr = 0; n_cmdv = 0; words_acc = 0;
        ov_first = -1; ov_last = -1; rr_first = -1;
        rise_q.delete(); dp_q.delete();
        exp_bits.delete(); exp_cmd.delete(); src_words.delete();
    endtask

    task automatic expect_cmd(input logic [2:0] op, input logic [1:0] sz);
        cmd_t c;
        c.op = op;
        c.sz = sz;
        exp_cmd.push_back(c);
    endtask

    task automatic fill(input int n, input logic [RES_W-1:0] first);
        src_words.push_back(first);
        for (int i = 1; i < n; i++) src_words.push_back(RES_W'($urandom()));
    endtask

    task automatic load_size(input logic [1:0] s);
        size_load = 1'b1;
        image_size = s;
        cycle();
        size_load = 1'b0;
    endtask

    // Entry i of the list sits at list[3*i +: 3].
    task automatic send(input int n, input logic [26:0] list);
        for (int i = 0; i < n; i++) begin
            in_valid2 = 1'b1;
            action = list[3*i +: 3];
            cycle();
        end
        in_valid2 = 1'b0;
        action = 3'd0;
    endtask

    task automatic run_pass(input int budget, input int words);
        for (int k = 0; k < budget && n_pass == 0; k++) cycle();
        for (int k = 0; k < 3; k++) cycle();
        check("pass_done_cnt", 32'(n_pass), 32'd1);
        check("cmd_left", 32'(exp_cmd.size()), 32'd0);
        check("bits_left", 32'(exp_bits.size()), 32'd0);
        check("words", 32'(words_acc), 32'(words));
        check("outv_cycles", 32'(n_outv), 32'(words * RES_W));
        check("busy_end", 32'(busy), 32'd0);
    endtask

    task automatic invalid_list(input string tag, input int n, input logic [26:0] list);
        clr();
        send(n, list);
        check({tag, "_err_early"}, 32'(seq_err), 32'd0);
        cycle();
        check({tag, "_err"}, 32'(seq_err), 32'd1);
        cycle();
        check({tag, "_err_pulse"}, 32'(seq_err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) cycle();
        check({tag, "_no_cmd"}, 32'(n_cmdv), 32'd0);
        check({tag, "_err_cnt"}, 32'(n_seqerr), 32'd1);
    endtask

    initial begin
        rst = 1'b1; size_load = 1'b0; image_size = 2'd0; in_valid2 = 1'b0; action = 3'd0;
        cmd_ready = 1'b0; dp_done = 1'b0; res_valid = 1'b0; res_data = '0;
        clr();
        cycle();
        cycle();
        check("rst_outs", 32'({busy, cmd_valid, cmd_op, cmd_size, res_ready, out_valid,
                               out_value, seq_err, pass_done}), 32'd0);
        rst = 1'b0;
        cycle();

        // Pass 1: size 1, list 0,3,7, ready tied high, results back to back.
        clr();
        cmd_ready = 1'b1;
        src_en = 1'b1;
        src_gap = 1'b0;
        load_size(2'd1);
        expect_cmd(3'd0, 2'd1);
        expect_cmd(3'd3, 2'd1);
        expect_cmd(3'd7, 2'd0);
        fill(16, 20'hA5A5A);
        send(3, {3'd7, 3'd3, 3'd0});
        check("lat_early", 32'(cmd_valid), 32'd0);
        cycle();
        check("lat_cmd", 32'(cmd_valid), 32'd1);
        run_pass(1000, 16);
        check("contig", 32'(ov_last - ov_first + 1), 32'd320);
        if (dp_q.size() >= 3 && rise_q.size() >= 3) begin
            check("next_cmd1", 32'(rise_q[1]), 32'(dp_q[0] + 1));
            check("next_cmd2", 32'(rise_q[2]), 32'(dp_q[1] + 1));
            check("serial_start", 32'(rr_first), 32'(dp_q[2] + 1));
            check("first_outv", 32'(ov_first), 32'(rr_first + 1));
        end else begin
            check("event_count", 32'(dp_q.size() + rise_q.size()), 32'd6);
        end

        // Pass 2: size 0, both pools skipped, results with gaps.
        clr();
        src_gap = 1'b1;
        load_size(2'd0);
        expect_cmd(3'd1, 2'd0);
        expect_cmd(3'd5, 2'd0);
        expect_cmd(3'd7, 2'd0);
        fill(16, 20'h0F0F1);
        send(5, {3'd7, 3'd5, 3'd3, 3'd3, 3'd1});
        run_pass(1500, 16);
        if (dp_q.size() >= 3 && rise_q.size() >= 3) begin
            check("skip_lat", 32'(rise_q[1]), 32'(dp_q[0] + 3));
            check("after_skip", 32'(rise_q[2]), 32'(dp_q[1] + 1));
        end else begin
            check("event_count2", 32'(dp_q.size() + rise_q.size()), 32'd6);
        end

        // Rejected lists: bad head, bad tail, one beat too many.
        src_gap = 1'b0;
        invalid_list("bad_head", 2, {3'd7, 3'd4});
        invalid_list("bad_tail", 2, {3'd3, 3'd0});
        invalid_list("ovf", 9, {3'd7, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd0});

        // A full queue of exactly eight entries is legal.
        clr();
        expect_cmd(3'd0, 2'd0);
        for (int i = 0; i < 6; i++) expect_cmd(3'd4, 2'd0);
        expect_cmd(3'd7, 2'd0);
        fill(16, 20'h12345);
        send(8, {3'd7, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd0});
        run_pass(1500, 16);
        check("full_no_err", 32'(n_seqerr), 32'd0);

        // Command stall: outputs hold while ready is low; stray dp_done ignored.
        clr();
        cmd_ready = 1'b0;
        expect_cmd(3'd2, 2'd0);
        expect_cmd(3'd7, 2'd0);
        fill(16, 20'hFFFFF);
        send(2, {3'd7, 3'd2});
        cycle();
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 32'(cmd_valid), 32'd1);
            check("stall_op", 32'(cmd_op), 32'd2);
            check("stall_size", 32'(cmd_size), 32'd0);
            if (k == 2) dp_timer = 1;
            cycle();
        end
        check("stall_after_dp", 32'(cmd_valid), 32'd1);
        cmd_ready = 1'b1;
        run_pass(1500, 16);

        // Reset during SERIAL on a clamped size-3 load, then a fresh pass at size 0.
        clr();
        load_size(2'd3);
        expect_cmd(3'd0, 2'd2);
        expect_cmd(3'd7, 2'd2);
        fill(20, 20'h00001);
        send(2, {3'd7, 3'd0});
        for (int k = 0; k < 300 && n_outv < 25; k++) cycle();
        check("abort_reached", 32'(n_outv >= 25), 32'd1);
        check("clamp_cmds", 32'(exp_cmd.size()), 32'd0);
        rst = 1'b1;
        cycle();
        check("abort_outs", 32'({busy, cmd_valid, cmd_op, cmd_size, res_ready, out_valid,
                                 out_value, seq_err, pass_done}), 32'd0);
        rst = 1'b0;
        dp_timer = 0;
        clr();
        cycle();
        expect_cmd(3'd0, 2'd0);
        expect_cmd(3'd7, 2'd0);
        fill(16, 20'hA5A5A);
        send(3, {3'd7, 3'd3, 3'd0});
        run_pass(1500, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/img_action_scheduler.md
# img_action_scheduler

Sequencing controller for the image/template processing engine. Captures the per-pass action list delivered on `in_valid2`/`action` and validates it. Issues each action as a command to the image datapath, tracking the shrinking working image size. It then serialises the 20-bit cross-correlation results onto the 1-bit `out_valid`/`out_value` output port.

## Interface
Parameters:
- `DEPTH`, 8: action queue depth, i.e. the maximum number of actions per pass.
- `RES_W`, 20: width of one correlation result.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `size_load`  in  1: pulse; latch `image_size` as the base size. Honoured only in IDLE.
- `image_size`  in  2: 0 = 4x4, 1 = 8x8, 2 = 16x16; 3 is clamped to 2.
- `in_valid2`  in  1: action beat valid.
- `action`  in  3: action code. 0/1/2 select grayscale max/avg/weighted; 3 max-pool; 4 negative; 5 horizontal flip; 6 median filter; 7 cross-correlation.
- `cmd_valid`  out  1: command to datapath valid.
- `cmd_op`  out  3: command opcode (same coding as `action`).
- `cmd_size`  out  2: working size for this command.
- `cmd_ready`  in  1: datapath accepts the command.
- `dp_done`  in  1: pulse; the accepted command has finished.
- `res_valid`  in  1: result word available.
- `res_data`  in  RES_W: result word.
- `res_ready`  out  1: controller consumes `res_data` this cycle.
- `out_valid`  out  1: serial output valid.
- `out_value`  out  1: serial output bit, MSB first.
- `busy`  out  1: high in any state other than IDLE.
- `seq_err`  out  1: one-cycle pulse when the action list is rejected.
- `pass_done`  out  1: one-cycle pulse when the last result bit has been sent.

## Operation
- **States:** IDLE, COLLECT, CHECK, ISSUE, WAIT, SERIAL, DONE.
- **IDLE:**
  - `size_load` latches `base_size`.
  - `in_valid2` pushes `action` into the queue and moves to COLLECT.
- **COLLECT:**
  - Each `in_valid2` cycle pushes one entry.
  - Pushes beyond DEPTH are dropped and set the internal `ovf` flag.
  - The first cycle with `in_valid2` low moves to CHECK.
- **CHECK (1 cycle):** the list is valid iff all of the following hold:
  - entry 0 is in 0..2;
  - the last entry is 7;
  - no other entry is 0..2 or 7;
  - `ovf` is clear.
- **Invalid list:**
  - `seq_err` pulses; the queue and `ovf` are cleared.
  - Next state is IDLE; no command is issued.
- **Valid list:** `cur_size` is loaded with `base_size`; next state is ISSUE.
- **ISSUE:**
  - Head opcode 3 with `cur_size` = 0 is popped without being issued (1 cycle), then ISSUE continues.
  - Otherwise `cmd_valid` = 1, `cmd_op` = head, `cmd_size` = `cur_size`, held stable until `cmd_ready`.
  - On handshake, pop and go to WAIT.
- **WAIT:**
  - On `dp_done`, if the op was 3, `cur_size` is decremented by 1.
  - If the op was 7, go to SERIAL with `remaining` = (4<<`cur_size`)² (16/64/256; 9-bit counter). Otherwise go to ISSUE.
  - `dp_done` outside WAIT is ignored.
- **SERIAL:**
  - `res_ready` = 1 when the shifter is empty, or on its last bit (`bitcnt` = RES_W-1), and `remaining` > 0.
  - `res_valid & res_ready` loads the shifter and decrements `remaining`.
  - Each loaded word drives exactly RES_W cycles of `out_valid` = 1, MSB first.
  - If no word is available, `out_valid` = 0 and `out_value` = 0.
  - After the last bit of the last word, go to DONE.
- **DONE (1 cycle):**
  - `pass_done` = 1, then IDLE.
  - `base_size` is retained for the next pass; the queue is emptied.
- `in_valid2` and `size_load` outside IDLE/COLLECT are ignored.

## Timing
- Reset values: every output 0; state IDLE; queue empty; `base_size` = 0; `cur_size` = 0; counters 0.
- Reset mid-operation aborts immediately; the next cycle behaves as after power-up.
- **Command latency:** last action beat at cycle t, CHECK at t+1, `cmd_valid` at t+2 at the earliest.
- **Skipped pools:** each skipped max-pool adds 1 cycle.
- **Next command:** `cmd_valid` rises the cycle after `dp_done`.
- **Serial start:** `res_ready` is first high in the cycle after the `dp_done` for op 7. The first `out_valid` is the cycle after the first accepted word.
- **Back-to-back words:** a word accepted in the last-bit cycle produces contiguous `out_valid` with no bubble.
- **Queue full:** exactly DEPTH entries are legal; entry DEPTH+1 forces `seq_err`.
- **Simultaneous events:** `res_valid` and the last bit in the same cycle count as a load, not a gap.

## Test plan
- `size_load` with size 1, then actions 0,3,7 with `cmd_ready` tied high:
  - commands (0,1), (3,1), (7,0);
  - 16 words accepted, 320 `out_valid` cycles, one `pass_done` pulse.
- Size 0, actions 1,3,3,5,7:
  - both pools are skipped; issued commands are (1,0), (5,0), (7,0);
  - 16 results serialised.
- Invalid lists (4,7), (0,3), or 9 beats:
  - `seq_err` pulses 2 cycles after the last beat;
  - `cmd_valid` never rises; `busy` returns low.
- Result 0xA5A5A received as a single word: `out_value` is 1010_0101_1010_0101_1010 MSB first. With `res_valid` held high, no gap between words.
- `cmd_ready` held low 5 cycles: `cmd_valid`, `cmd_op` and `cmd_size` stay stable. A `dp_done` injected during ISSUE is ignored.
- `rst` asserted mid-SERIAL: the next cycle has all outputs 0 and state IDLE. A fresh pass runs correctly with `base_size` = 0.
